// File: rtl/divide.sv
// divide: iterative 32-bit restoring divider, one quotient bit per DIV2 cycle.
// Define DIV_SIGNED_EN for signed DIV semantics; otherwise unsigned DIVU.
module divide #(
    parameter logic [5:0] DIV_STATE  = 6'd34,
    parameter logic [5:0] DIV2_STATE = 6'd35
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  State,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        EndDivFlag,
    output logic        DivZero
);
    logic [31:0] r_rem, r_q, r_div, r_a;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic [31:0] w_a_mag, w_b_mag, w_rem_next, w_q_next, w_lo, w_hi;
    logic [32:0] w_shift;
    logic        w_ge;
    assign w_shift    = {r_rem, r_q[31]};
    assign w_ge       = w_shift >= {1'b0, r_div};
    assign w_rem_next = w_ge ? w_shift[31:0] - r_div : w_shift[31:0];
    assign w_q_next   = {r_q[30:0], w_ge};
`ifdef DIV_SIGNED_EN
    logic r_qneg, r_rneg;
    assign w_a_mag = A[31] ? -A : A;
    assign w_b_mag = B[31] ? -B : B;
    assign w_lo    = r_qneg ? -w_q_next : w_q_next;
    assign w_hi    = r_rneg ? -w_rem_next : w_rem_next;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (State == DIV_STATE) begin
            r_qneg <= A[31] ^ B[31];
            r_rneg <= A[31];
        end
    end
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_lo    = w_q_next;
    assign w_hi    = w_rem_next;
`endif
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rem      <= '0;
            r_q        <= '0;
            r_div      <= '0;
            r_a        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            Hi         <= '0;
            Lo         <= '0;
            EndDivFlag <= 1'b0;
            DivZero    <= 1'b0;
        end else if (State == DIV_STATE) begin
            r_q        <= w_a_mag;
            r_div      <= w_b_mag;
            r_a        <= A;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            DivZero    <= (B == '0);
            EndDivFlag <= 1'b0;
        end else if (State == DIV2_STATE && r_busy) begin
            // A zero divisor short-circuits to the MIPS-style fixed result.
            if (DivZero) begin
                Lo         <= '1;
                Hi         <= r_a;
                EndDivFlag <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                r_rem <= w_rem_next;
                r_q   <= w_q_next;
                r_cnt <= r_cnt + 6'd1;
                if (r_cnt == 6'd31) begin
                    Lo         <= w_lo;
                    Hi         <= w_hi;
                    EndDivFlag <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_divide.sv
// tb_divide: randomized and directed checks of divide against an arithmetic model.
module tb_divide;
    localparam logic [5:0] DIV = 6'd34, DIV2 = 6'd35;
    logic        Clk = 1'b0, Reset = 1'b0;
    logic [5:0]  State = 6'd0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] Hi, Lo;
    logic        EndDivFlag, DivZero;
    int total = 0, bad = 0;

    divide dut (.Clk(Clk), .Reset(Reset), .State(State), .A(A), .B(B),
                .Hi(Hi), .Lo(Lo), .EndDivFlag(EndDivFlag), .DivZero(DivZero));

    always #5 Clk = ~Clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SIGNED_EN
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sa % sb), 32'(sa / sb)};
`else
        return {a % b, a / b};
`endif
    endfunction

    // Model: result computed by arithmetic at load, released after 32 DIV2 edges.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_eh = '0, m_el = '0;
    logic        m_flag = 1'b0, m_dz = 1'b0, m_busy = 1'b0;
    int          m_cnt = 0;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_hi <= '0; m_lo <= '0; m_flag <= 1'b0; m_dz <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
        end else if (State == DIV) begin
            m_busy <= 1'b1; m_cnt <= 0; m_dz <= (B == 0); m_flag <= 1'b0; m_a <= A;
            if (B != 0) {m_eh, m_el} <= ref_div(A, B);
        end else if (State == DIV2 && m_busy) begin
            if (m_dz) begin
                m_lo <= 32'hFFFFFFFF; m_hi <= m_a; m_flag <= 1'b1; m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 31) begin
                    m_lo <= m_el; m_hi <= m_eh; m_flag <= 1'b1; m_busy <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            check("cyc_lo", Lo, m_lo);
            check("cyc_hi", Hi, m_hi);
            check("cyc_flag", {31'd0, EndDivFlag}, {31'd0, m_flag});
            check("cyc_dz", {31'd0, DivZero}, {31'd0, m_dz});
        end
    end

    task automatic drive(input logic [5:0] st);
        State = st;
        @(negedge Clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        drive(DIV);
        A = $urandom;
        B = $urandom;
    endtask

    task automatic run_to_end(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] elo, input logic [31:0] ehi);
        load(a, b);
        repeat (31) drive(DIV2);
        check({name, "_flag_early"}, {31'd0, EndDivFlag}, 32'd0);
        drive(DIV2);
        check({name, "_flag"}, {31'd0, EndDivFlag}, 32'd1);
        check({name, "_lo"}, Lo, elo);
        check({name, "_hi"}, Hi, ehi);
    endtask

    logic [31:0] ra, rb;
    int          budget;

    initial begin
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_lo", Lo, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_flag", {31'd0, EndDivFlag}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        run_to_end("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        repeat (3) drive(DIV2);
        check("post_lo", Lo, 32'd14);
        check("post_hi", Hi, 32'd2);
`ifdef DIV_SIGNED_EN
        run_to_end("neg7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_to_end("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
`else
        run_to_end("neg7_2", 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
        run_to_end("ovf", 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
`endif
        load(32'd5, 32'd0);
        check("dz_flag_at_load", {31'd0, DivZero}, 32'd1);
        check("dz_end_at_load", {31'd0, EndDivFlag}, 32'd0);
        drive(DIV2);
        check("dz_lo", Lo, 32'hFFFFFFFF);
        check("dz_hi", Hi, 32'd5);
        check("dz_end", {31'd0, EndDivFlag}, 32'd1);

        load(32'd1000, 32'd10);
        repeat (10) drive(DIV2);
        repeat (3) drive(6'd0);
        repeat (21) drive(DIV2);
        check("pause_early", {31'd0, EndDivFlag}, 32'd0);
        drive(DIV2);
        check("pause_flag", {31'd0, EndDivFlag}, 32'd1);
        check("pause_lo", Lo, 32'd100);
        check("pause_hi", Hi, 32'd0);

        load(32'd12345, 32'd67);
        repeat (20) drive(DIV2);
        State = 6'd0;
        #2 Reset = 1'b1;
        #1;
        check("arst_lo", Lo, 32'd0);
        check("arst_hi", Hi, 32'd0);
        check("arst_flag", {31'd0, EndDivFlag}, 32'd0);
        check("arst_dz", {31'd0, DivZero}, 32'd0);
        #1 Reset = 1'b0;
        @(negedge Clk);
        run_to_end("d9_4", 32'd9, 32'd4, 32'd2, 32'd1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: ra = $urandom_range(0, 1000);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(1, 20);
                3: rb = 32'd1;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            load(ra, rb);
            budget = 0;
            while (!m_flag && budget < 200) begin
                budget++;
                if ($urandom_range(0, 99) < 2) load($urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
                else if ($urandom_range(0, 99) < 15) drive(6'($urandom_range(0, 33)));
                else drive(DIV2);
            end
            total++;
            if (!m_flag) begin
                bad++;
                $display("FAIL rand_timeout: op %0d did not complete within budget %0d", n, budget);
            end
            repeat ($urandom_range(0, 2)) drive(DIV2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/divide.md
# divide

Iterative 32-bit restoring divider for the MIPS datapath: the divide-side counterpart of the multiplier. Sequenced by the control unit through the shared 6-bit `State` bus, it loads operands in one state, iterates one quotient bit per cycle in a second state, and raises a completion flag when `Hi`/`Lo` are valid for MFHI/MFLO.

## Interface
- `DIV_STATE`, default 34: `State` code that loads operands (DIV).
- `DIV2_STATE`, default 35: `State` code that performs one iteration (DIV2).
- `Clk` input, 1 bit: clock, rising edge.
- `Reset` input, 1 bit: reset, asynchronous, active-high.
- `State` input, 6 bits: control-unit state code.
- `A` input, 32 bits: dividend (rs).
- `B` input, 32 bits: divisor (rt).
- `Hi` output, 32 bits: remainder.
- `Lo` output, 32 bits: quotient.
- `EndDivFlag` output, 1 bit: result valid. Held until the next load or reset.
- `DivZero` output, 1 bit: the current operation has divisor 0.

## Operation
- Reset, asynchronous: `Hi`=0, `Lo`=0, `EndDivFlag`=0, `DivZero`=0. Internal counter=0 and the internal busy bit=0.
- **Load.** On an edge with `State==DIV_STATE`:
  - Capture `|A|` into the quotient/dividend shift register and `|B|` into the divisor register. Magnitudes apply in signed mode only; otherwise raw values.
  - Zero the partial remainder and set counter=0.
  - Latch `qneg = A[31]^B[31]` and `rneg = A[31]` (signed mode only).
  - Set `DivZero = (B==0)`, `EndDivFlag`=0, busy=1.
  - `Hi`/`Lo` keep their old values.
- **Iteration.** On an edge with `State==DIV2_STATE`, busy=1, `DivZero`=0:
  - Shift `{rem, q}` left by 1.
  - If `rem >= divisor` (33-bit compare), subtract the divisor and set `q[0]=1`.
  - Increment counter.
  - When counter reaches 32, write `Lo` = q (negated if `qneg`) and `Hi` = rem (negated if `rneg`). Set `EndDivFlag`=1 and busy=0.
- **Divide by zero.** First DIV2 edge after load with `DivZero`=1:
  - `Lo`=32'hFFFFFFFF, `Hi`=A as captured (raw), `EndDivFlag`=1, busy=0. No iterations run.
- **Overflow.** Signed `0x80000000 / -1` gives `Lo`=0x80000000, `Hi`=0 (falls out of magnitude arithmetic). No trap.
- **Pause.** Any other `State` value holds all registers. Iteration resumes on return to DIV2.
- **Post-completion.** DIV2 edges with busy=0 change nothing.
- **Restart.** DIV during an operation aborts it and restarts from new operands.
- **Reset mid-operation.** Returns to the reset values; a partial result is never written.

## Timing
- Load edge L; iterations on 32 consecutive DIV2 edges L+1 … L+32.
- `Hi`, `Lo`, `EndDivFlag` update together at edge L+32, the same edge as the sign fix-up. Latency is 33 edges.
- Divide by zero completes at edge L+1.
- `DivZero` is valid from edge L.
- The control unit must hold DIV2 until it samples `EndDivFlag`=1.
- Each pause cycle outside DIV2 adds one cycle of latency.

## Configuration
- `DIV_SIGNED_EN` defined: DIV semantics.
  - Operands are two's-complement.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Undefined: DIVU semantics.
  - Operands are unsigned.
  - `qneg`/`rneg` are forced to 0 and no negation logic is built.
  - Result `0x80000000 / 0xFFFFFFFF` gives `Lo`=0, `Hi`=0x80000000.

## Test plan
- A=100, B=7, DIV then 32×DIV2 → at edge L+32: `Lo`=14, `Hi`=2, `EndDivFlag`=1; flag low through edge L+31.
- Signed: A=-7 (0xFFFFFFF9), B=2 → `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF. Unsigned build: same operands → `Lo`=0x7FFFFFFC, `Hi`=1.
- A=5, B=0 → `DivZero`=1 at edge L. At edge L+1: `Lo`=0xFFFFFFFF, `Hi`=5, `EndDivFlag`=1.
- Signed: A=0x80000000, B=0xFFFFFFFF → `Lo`=0x80000000, `Hi`=0.
- A=1000, B=10, with `State`=0 inserted for 3 cycles after iteration 10 → completes at edge L+35 with `Lo`=100, `Hi`=0.
- `Reset` pulsed asynchronously after iteration 20 → all outputs 0 immediately; a fresh DIV of 9/4 then gives `Lo`=2, `Hi`=1.
